// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time, byte-lane strobes and load extension.
// Optional MISALIGN_TRAP_EN: misaligned H/HU/W faults instead of having the address force-aligned.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_Req,
  input  logic        i_We,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_Wd,
  output logic        o_Ready,
  output logic        o_Ack,
  output logic [31:0] o_Rdata,
  output logic        o_Fault,
  output logic [31:0] o_Addr,
  output logic [31:0] o_Wd,
  output logic [3:0]  o_Wen,
  output logic        o_Ren,
  input  logic [31:0] i_Rd,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken on a rising edge where o_Ready and i_Req are both 1.
  // Each taken request gets exactly one o_Ack pulse carrying o_Fault and o_Rdata.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        accept;
  logic        illegal;
  logic        fault_in;
  logic [31:0] addr_eff;
  logic [3:0]  wen_eff;
  logic [31:0] wd_eff;
  logic [31:0] rd_shift;
  logic [31:0] load_val;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
`endif

  assign accept    = (state == IDLE) && i_Req;
  assign o_Ready   = (state == IDLE);
  assign dbg_state = state;

  always_comb begin
    illegal  = 1'b0;
    fault_in = 1'b0;
    addr_eff = i_Addr;
    wen_eff  = 4'b0000;
    wd_eff   = i_Wd;
    case (i_Funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = i_We;
      default:                illegal = 1'b1;
    endcase
`ifdef MISALIGN_TRAP_EN
    misaligned = ((i_Funct3[1:0] == 2'b01) && i_Addr[0]) ||
                 ((i_Funct3[1:0] == 2'b10) && (i_Addr[1:0] != 2'b00));
    fault_in   = illegal | misaligned;
`else
    fault_in = illegal;
    if (i_Funct3[1:0] == 2'b01) addr_eff[0] = 1'b0;
    else if (i_Funct3[1:0] == 2'b10) addr_eff[1:0] = 2'b00;
`endif
    // Lane enables follow the (possibly aligned) byte offset; data is replicated to every lane.
    case (i_Funct3[1:0])
      2'b00: begin
        wen_eff = 4'b0001 << addr_eff[1:0];
        wd_eff  = {4{i_Wd[7:0]}};
      end
      2'b01: begin
        wen_eff = 4'b0011 << addr_eff[1:0];
        wd_eff  = {2{i_Wd[15:0]}};
      end
      default: begin
        wen_eff = 4'b1111;
        wd_eff  = i_Wd;
      end
    endcase
  end

  always_comb begin
    rd_shift = i_Rd >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_val = {24'h000000, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_val = {16'h0000, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Req) state_nxt = fault_in ? RESP : ISSUE;
      ISSUE:   state_nxt = r_we ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      o_Ack    <= 1'b0;
      o_Fault  <= 1'b0;
      o_Rdata  <= 32'h0;
      o_Addr   <= 32'h0;
      o_Wd     <= 32'h0;
      o_Wen    <= 4'b0000;
      o_Ren    <= 1'b0;
    end else begin
      o_Wen   <= 4'b0000;
      o_Ren   <= 1'b0;
      o_Ack   <= 1'b0;
      o_Fault <= 1'b0;
      if (accept) begin
        r_we     <= i_We;
        r_funct3 <= i_Funct3;
        r_off    <= addr_eff[1:0];
        if (fault_in) begin
          o_Ack   <= 1'b1;
          o_Fault <= 1'b1;
        end else begin
          o_Addr <= addr_eff;
          if (i_We) begin
            o_Wen <= wen_eff;
            o_Wd  <= wd_eff;
          end else begin
            o_Ren <= 1'b1;
          end
        end
      end
      if ((state == ISSUE) && r_we) o_Ack <= 1'b1;
      // Read data arrives one cycle after the ISSUE-cycle read strobe.
      if (state == WAIT) begin
        o_Ack   <= 1'b1;
        o_Rdata <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, reset aborts and random traffic
// checked against a byte-addressed reference model of the memory and the access rules.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_Req = 1'b0;
  logic        i_We = 1'b0;
  logic [2:0]  i_Funct3 = 3'b000;
  logic [31:0] i_Addr = 32'h0;
  logic [31:0] i_Wd = 32'h0;
  logic        o_Ready, o_Ack, o_Fault, o_Ren;
  logic [31:0] o_Rdata, o_Addr, o_Wd;
  logic [3:0]  o_Wen;
  logic [31:0] i_Rd = 32'h0;
  logic [1:0]  dbg_state;

  load_store_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_Req(i_Req), .i_We(i_We), .i_Funct3(i_Funct3),
    .i_Addr(i_Addr), .i_Wd(i_Wd), .o_Ready(o_Ready), .o_Ack(o_Ack), .o_Rdata(o_Rdata),
    .o_Fault(o_Fault), .o_Addr(o_Addr), .o_Wd(o_Wd), .o_Wen(o_Wen), .o_Ren(o_Ren),
    .i_Rd(i_Rd), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // memory environment: 16 words, lane-enabled writes, registered read
  logic [31:0] env_mem [16];
  logic        mem_init = 1'b1;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always @(posedge i_clk) begin
    if (mem_init) begin
      for (int w = 0; w < 16; w++) env_mem[w] <= init_word(w);
    end else begin
      if (o_Ren) i_Rd <= env_mem[o_Addr[5:2]];
      for (int b = 0; b < 4; b++)
        if (o_Wen[b]) env_mem[o_Addr[5:2]][8*b +: 8] <= o_Wd[8*b +: 8];
    end
  end

  // reference model state
  logic [7:0]  ref_mem [64];
  logic [31:0] model_rdata;

  // scoreboard
  int passed = 0;
  int fails = 0;
  int total = 0;

  int          obs_lat;
  logic        obs_fault;
  logic [31:0] obs_rdata, obs_wd;
  logic [3:0]  obs_wen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver + model for one access
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold);
    int          size, exp_lat;
    bit          illegal, misal, fault, got;
    logic [31:0] eff, exp_wd, val;
    logic [3:0]  exp_wen;

    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    misal   = (addr % size) != 0;
    eff     = addr - (addr % size);
`ifdef MISALIGN_TRAP_EN
    fault = illegal || misal;
`else
    fault = illegal;
`endif
    exp_wen = 4'b0000;
    exp_wd  = 32'h0;
    if (!fault) begin
      if (we) begin
        for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % size) +: 8];
        for (int i = 0; i < size; i++) begin
          exp_wen[(eff % 4) + i] = 1'b1;
          ref_mem[eff[5:0] + i] = wd[8*i +: 8];
        end
      end else begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[eff[5:0] + i];
        if (!f3[2] && size < 4 && val[8*size-1])
          val = val | ~((32'd1 << (8*size)) - 32'd1);
        model_rdata = val;
      end
    end
    exp_lat = fault ? 1 : (we ? 2 : 3);

    for (int n = 0; n < 20 && o_Ready !== 1'b1; n++) @(negedge i_clk);
    chk("ready_before_req", {31'b0, o_Ready}, 32'd1);
    i_Req = 1'b1; i_We = we; i_Funct3 = f3; i_Addr = addr; i_Wd = wd;
    @(posedge i_clk);

    got = 0; obs_lat = 0; obs_fault = 1'bx; obs_rdata = 32'hx; obs_wen = 4'hx; obs_wd = 32'hx;
    for (int cyc = 1; cyc <= 8 && !got; cyc++) begin
      @(negedge i_clk);
      if (!hold) i_Req = 1'b0;
      else begin
        i_We = 1'($urandom); i_Funct3 = 3'($urandom); i_Addr = $urandom; i_Wd = $urandom;
      end
      chk("strobe_exclusive", {31'b0, (o_Wen != 4'b0) && o_Ren}, 32'd0);
      chk("wen", {28'b0, o_Wen}, (cyc == 1) ? {28'b0, exp_wen} : 32'd0);
      chk("ren", {31'b0, o_Ren}, {31'b0, (cyc == 1) && !we && !fault});
      if (cyc == 1 && !fault) begin
        chk("mem_addr", o_Addr, eff);
        if (we) chk("mem_wd", o_Wd, exp_wd);
      end
      if (cyc == 1) begin obs_wen = o_Wen; obs_wd = o_Wd; end
      chk("ready_busy", {31'b0, o_Ready}, 32'd0);
      if (o_Ack === 1'b1) begin
        got = 1; obs_lat = cyc; obs_fault = o_Fault; obs_rdata = o_Rdata;
      end
    end
    i_Req = 1'b0;
    chk("ack_latency", obs_lat, exp_lat);
    chk("fault", {31'b0, obs_fault}, {31'b0, fault});
    chk("rdata", obs_rdata, model_rdata);
    @(negedge i_clk);
    chk("ack_single_pulse", {31'b0, o_Ack}, 32'd0);
    chk("ready_after", {31'b0, o_Ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, {31'b0, o_Ack}, 32'd0);
    chk({tag, "_fault"}, {31'b0, o_Fault}, 32'd0);
    chk({tag, "_rdata"}, o_Rdata, 32'd0);
    chk({tag, "_addr"}, o_Addr, 32'd0);
    chk({tag, "_wd"}, o_Wd, 32'd0);
    chk({tag, "_wen"}, {28'b0, o_Wen}, 32'd0);
    chk({tag, "_ren"}, {31'b0, o_Ren}, 32'd0);
    chk({tag, "_ready"}, {31'b0, o_Ready}, 32'd1);
  endtask

  task automatic release_and_watch(input string tag);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk({tag, "_no_ack"}, {31'b0, o_Ack}, 32'd0);
      chk({tag, "_ready"}, {31'b0, o_Ready}, 32'd1);
    end
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w) >> (8*b);
    model_rdata = 32'h0;

    // reset state
    repeat (2) @(negedge i_clk);
    check_reset_outputs("reset");
    mem_init = 1'b0;
    i_rst = 1'b0;
    @(negedge i_clk);

    // SW
    run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    chk("sw_wen", {28'b0, obs_wen}, 32'h0000000F);
    chk("sw_wd", obs_wd, 32'hDEADBEEF);
    chk("sw_latency", obs_lat, 2);

    // SB to the top lane
    run_op(1'b1, 3'b000, 32'h13, 32'h000000A5, 0);
    chk("sb_wen", {28'b0, obs_wen}, 32'h00000008);
    chk("sb_wd", obs_wd, 32'hA5A5A5A5);

    // LB / LBU
    run_op(1'b1, 3'b010, 32'h20, 32'h1234F0AA, 0);
    run_op(1'b0, 3'b000, 32'h21, 32'h0, 0);
    chk("lb_rdata", obs_rdata, 32'hFFFFFFF0);
    chk("lb_latency", obs_lat, 3);
    run_op(1'b0, 3'b100, 32'h21, 32'h0, 0);
    chk("lbu_rdata", obs_rdata, 32'h000000F0);

    // LH upper half, then misaligned LW
    run_op(1'b1, 3'b010, 32'h04, 32'h80017FFF, 0);
    run_op(1'b0, 3'b001, 32'h06, 32'h0, 0);
    chk("lh_rdata", obs_rdata, 32'hFFFF8001);
    run_op(1'b0, 3'b010, 32'h06, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("lw_mis_fault", {31'b0, obs_fault}, 32'd1);
    chk("lw_mis_latency", obs_lat, 1);
`else
    chk("lw_mis_rdata", obs_rdata, 32'h80017FFF);
    chk("lw_mis_fault", {31'b0, obs_fault}, 32'd0);
`endif

    // illegal funct3 load: fault, no strobes, rdata held
    run_op(1'b0, 3'b011, 32'h08, 32'h0, 0);
    chk("f011_fault", {31'b0, obs_fault}, 32'd1);
    chk("f011_latency", obs_lat, 1);
    chk("f011_wen", {28'b0, obs_wen}, 32'd0);

    // i_Req held high with changing inputs while busy
    run_op(1'b1, 3'b001, 32'h2A, $urandom, 1);
    run_op(1'b0, 3'b101, 32'h2A, 32'h0, 1);

    // reset during WAIT of a load
    for (int n = 0; n < 20 && o_Ready !== 1'b1; n++) @(negedge i_clk);
    i_Req = 1'b1; i_We = 1'b0; i_Funct3 = 3'b010; i_Addr = 32'h08; i_Wd = 32'h0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_Req = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    model_rdata = 32'h0;
    release_and_watch("rst_wait");

    // reset during ISSUE of a store: the write must not land
    i_Req = 1'b1; i_We = 1'b1; i_Funct3 = 3'b010; i_Addr = 32'h30; i_Wd = 32'h13579BDF;
    @(posedge i_clk);
    @(negedge i_clk);
    i_Req = 1'b0;
    chk("rst_issue_wen_before", {28'b0, o_Wen}, 32'h0000000F);
    i_rst = 1'b1;
    #1;
    check_reset_outputs("rst_issue");
    release_and_watch("rst_issue");
    run_op(1'b0, 3'b010, 32'h30, 32'h0, 0);

    // random traffic
    repeat (80) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      run_op(1'($urandom_range(0, 1)), f3, 32'($urandom_range(0, 63)), $urandom,
             $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
